ls_ctrl: RTL and testbench
==========================

LS_CTRL -- requirements
Module: ls_ctrl

Interface
REQ-001 SHALL have: clk  in  1  system clock; all state changes on posedge.
REQ-002 SHALL have: rst  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-003 SHALL have: rdy  in  1  global enable; when low, all state holds and mem_wr=0.
REQ-004 SHALL have: rs_busy  in  1  load/store station entry valid.
REQ-005 SHALL have: rs_op  in  sinst_t  LB/LH/LW/LBU/LHU/SB/SH/SW.
REQ-006 SHALL have: rs_offset, rs_datax, rs_datay  in  32 each  immediate, base, store data.
REQ-007 SHALL have: rs_tagx, rs_tagy, rs_tagw  in  regtag_t  operand/destination tags.
REQ-008 SHALL have: busy_ls  out  1  fed back to station; high from accept until done.
REQ-009 SHALL have: en_ls  out  1  one-cycle result broadcast strobe; ls_data  out  32; ls_tag  out  regtag_t.
REQ-010 SHALL have: if_req  in  1; if_addr  in  32; if_gnt  out  1  fetch-port sharing.
REQ-011 SHALL have: mem_a  out  32; mem_dout  out  8; mem_din  in  8; mem_wr  out  1  byte memory port, read data valid one cycle after address.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, ACCESS, DRAIN, DONE.
REQ-013 IDLE -> ADDR SHALL occur when rs_busy=1 and rs_tagx=UNLOCKED and (load or rs_tagy=UNLOCKED); otherwise stay.
REQ-014 ADDR SHALL latch op, tagw, store data, addr=rs_datax+rs_offset (mod 2^32), byte count n=1/2/4 from op.
REQ-015 ACCESS SHALL drive byte k (k=0..n-1, little-endian) at addr+k, one byte per cycle; stores set mem_wr=1, mem_dout=data[8k+7:8k].
REQ-016 Loads SHALL capture mem_din for byte k in the cycle after byte k is addressed; DRAIN captures the final byte.
REQ-017 Stores SHALL skip DRAIN: ACCESS -> DONE after byte n-1.
REQ-018 DONE SHALL pulse en_ls=1 for exactly one cycle with ls_tag=latched tagw; then IDLE.
REQ-019 ls_data SHALL be sign-extended for LB/LH, zero-extended for LBU/LHU, full for LW, 0 for stores.
REQ-020 busy_ls SHALL be 1 from the ADDR cycle through DONE inclusive, 0 in IDLE.
REQ-021 if_gnt SHALL be 1 iff state is IDLE or ADDR and if_req=1; then mem_a=if_addr, mem_wr=0.
REQ-022 In ACCESS/DRAIN, LS SHALL own the port; if_gnt=0 regardless of if_req.
REQ-023 Total latency accept->en_ls SHALL be n+3 cycles for loads, n+2 for stores.
REQ-024 Idle port SHALL drive mem_a=0, mem_dout=0, mem_wr=0.
REQ-025 rs_busy dropping mid-operation SHALL NOT abort; operation completes from latched values.
REQ-026 rdy=0 SHALL freeze FSM, byte counter and captured data; mem_wr=0 and if_gnt=0 while frozen.

Reset
REQ-027 On rst=0, state=IDLE, busy_ls=0, en_ls=0, ls_data=0, ls_tag=UNLOCKED, mem_wr=0, mem_a=0, mem_dout=0, if_gnt=0, immediately and asynchronously.
REQ-028 Reset asserted mid-store SHALL stop further byte writes; already-written bytes are not undone.

Configuration
REQ-029 Macro LS_MISALIGN_CHECK_EN: when defined, ADDR SHALL detect halfword addr[0]=1 or word addr[1:0]!=0, skip ACCESS, go to DONE with ls_data=0 and misalign output=1 during en_ls.
REQ-030 Without LS_MISALIGN_CHECK_EN, misaligned accesses SHALL proceed byte-wise normally and the misalign port SHALL be absent.

Structure
REQ-031 sinst_t encodings, regtag_t, UNLOCKED, word_t SHALL come from the shared CPU definitions package; no local copies.
REQ-032 Load extension SHALL be a sub-module ls_extend (op, raw 32 -> data 32), purely combinational.

Verification
REQ-033 LW base=0x100, offset=4, memory 0x104..0x107=11 22 33 44 -> en_ls at cycle 7 after accept, ls_data=0x44332211.
REQ-034 LB at byte 0x80 -> ls_data=0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH data=0xABCD at 0x200 -> mem_wr pulses at 0x200=CD, 0x201=AB, en_ls 4 cycles after accept, no DRAIN.
REQ-036 rs_tagx locked for 5 cycles, if_req=1 throughout -> if_gnt=1 each cycle, busy_ls=0; unlock -> access starts next cycle.
REQ-037 rst=0 asserted during byte 2 of SW -> bytes 0-1 written, no further mem_wr, en_ls never asserts, outputs at reset values.
REQ-038 With LS_MISALIGN_CHECK_EN, LW at 0x102 -> no mem traffic, en_ls with misalign=1, ls_data=0.

Source files
------------

// File: rtl/ls_ctrl_pkg.sv
// Shared CPU definitions: word/tag types, load/store opcodes and small opcode helpers
// used by the load/store controller and its consumers.
package ls_ctrl_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regtag_t;

  localparam regtag_t UNLOCKED = 5'd0;

  typedef enum logic [3:0] {
    LB  = 4'h0,
    LH  = 4'h1,
    LW  = 4'h2,
    LBU = 4'h4,
    LHU = 4'h5,
    SB  = 4'h8,
    SH  = 4'h9,
    SW  = 4'hA
  } sinst_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ACCESS,
    S_DRAIN,
    S_DONE
  } ls_state_t;

  function automatic logic is_store(input sinst_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Index of the final byte of the access (byte count minus one).
  function automatic logic [1:0] last_byte(input sinst_t op);
    case (op)
      LB, LBU, SB: last_byte = 2'd0;
      LH, LHU, SH: last_byte = 2'd1;
      default:     last_byte = 2'd3;
    endcase
  endfunction

  function automatic logic is_misaligned(input sinst_t op, input word_t addr);
    case (op)
      LH, LHU, SH: is_misaligned = addr[0];
      LW, SW:      is_misaligned = (addr[1:0] != 2'b00);
      default:     is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ls_ctrl_extend.sv
// Load result extension: sign/zero-extends the assembled little-endian bytes per opcode.
module ls_extend
  import ls_ctrl_pkg::*;
(
  input  sinst_t op,
  input  word_t  raw,
  output word_t  data
);

  always_comb begin
    data = '0;
    case (op)
      LB:      data = {{24{raw[7]}}, raw[7:0]};
      LH:      data = {{16{raw[15]}}, raw[15:0]};
      LW:      data = raw;
      LBU:     data = {24'b0, raw[7:0]};
      LHU:     data = {16'b0, raw[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/ls_ctrl.sv
// Load/store controller: serialises LB..SW onto a byte-wide memory port shared with fetch.
// Define LS_MISALIGN_CHECK_EN to trap misaligned halfword/word accesses via the misalign port.
module ls_ctrl
  import ls_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       rs_busy,
  input  sinst_t     rs_op,
  input  word_t      rs_offset,
  input  word_t      rs_datax,
  input  word_t      rs_datay,
  input  regtag_t    rs_tagx,
  input  regtag_t    rs_tagy,
  input  regtag_t    rs_tagw,
  output logic       busy_ls,
  output logic       en_ls,
  output word_t      ls_data,
  output regtag_t    ls_tag,
  input  logic       if_req,
  input  word_t      if_addr,
  output logic       if_gnt,
  output word_t      mem_a,
  output logic [7:0] mem_dout,
  input  logic [7:0] mem_din,
  output logic       mem_wr
`ifdef LS_MISALIGN_CHECK_EN
  ,
  output logic       misalign
`endif
);

  ls_state_t  r_state;
  sinst_t     r_op;
  regtag_t    r_tagw;
  word_t      r_sdata;
  word_t      r_addr;
  word_t      r_raw;
  logic [1:0] r_k;
  logic [1:0] r_pend_k;
  logic       r_pend;
  logic       r_en_ls;
  word_t      r_ls_data;
  regtag_t    r_ls_tag;
`ifdef LS_MISALIGN_CHECK_EN
  logic       r_mis;
`endif

  logic       w_accept;
  logic       w_take;
  logic       w_store;
  logic [1:0] w_last;
  word_t      w_raw;
  word_t      w_ext;

  assign w_accept = rs_busy && (rs_tagx == UNLOCKED) &&
                    (!is_store(rs_op) || (rs_tagy == UNLOCKED));
  assign w_take   = rdy && (r_state == S_IDLE) && w_accept;
  assign w_store  = is_store(r_op);
  assign w_last   = last_byte(r_op);

  // A read issued last cycle lands on mem_din now; merge it so DRAIN can finish in one cycle.
  always_comb begin
    w_raw = r_raw;
    if (r_pend) w_raw[{r_pend_k, 3'b000} +: 8] = mem_din;
  end

  ls_extend u_extend (
    .op   (r_op),
    .raw  (w_raw),
    .data (w_ext)
  );

  always_ff @(posedge clk) begin
    if (w_take) begin
      r_op    <= rs_op;
      r_tagw  <= rs_tagw;
      r_sdata <= rs_datay;
      r_addr  <= rs_datax + rs_offset;
    end
    if (rdy && (r_state == S_ACCESS)) r_pend_k <= r_k;
    r_raw <= w_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_k       <= '0;
      r_pend    <= 1'b0;
      r_en_ls   <= 1'b0;
      r_ls_data <= '0;
      r_ls_tag  <= UNLOCKED;
`ifdef LS_MISALIGN_CHECK_EN
      r_mis     <= 1'b0;
`endif
    end else begin
      // An in-flight read always completes, even while frozen.
      r_pend <= 1'b0;
      if (rdy) begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) r_state <= S_ADDR;
          end
          S_ADDR: begin
            r_k     <= '0;
            r_state <= S_ACCESS;
`ifdef LS_MISALIGN_CHECK_EN
            if (is_misaligned(r_op, r_addr)) begin
              r_state   <= S_DONE;
              r_en_ls   <= 1'b1;
              r_ls_data <= '0;
              r_ls_tag  <= r_tagw;
              r_mis     <= 1'b1;
            end
`endif
          end
          S_ACCESS: begin
            r_pend <= !w_store;
            if (r_k == w_last) begin
              if (w_store) begin
                r_state   <= S_DONE;
                r_en_ls   <= 1'b1;
                r_ls_data <= '0;
                r_ls_tag  <= r_tagw;
              end else begin
                r_state <= S_DRAIN;
              end
            end else begin
              r_k <= r_k + 2'd1;
            end
          end
          S_DRAIN: begin
            r_state   <= S_DONE;
            r_en_ls   <= 1'b1;
            r_ls_data <= w_ext;
            r_ls_tag  <= r_tagw;
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_en_ls <= 1'b0;
`ifdef LS_MISALIGN_CHECK_EN
            r_mis   <= 1'b0;
`endif
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_ls = (r_state != S_IDLE);
  assign en_ls   = r_en_ls && rdy;
  assign ls_data = r_ls_data;
  assign ls_tag  = r_ls_tag;
`ifdef LS_MISALIGN_CHECK_EN
  assign misalign = r_mis && en_ls;
`endif

  // Fetch may borrow the port only while the unit has not started touching memory.
  always_comb begin
    if_gnt   = 1'b0;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (rst && rdy) begin
      if (((r_state == S_IDLE) || (r_state == S_ADDR)) && if_req) begin
        if_gnt = 1'b1;
        mem_a  = if_addr;
      end else if (r_state == S_ACCESS) begin
        mem_a = r_addr + {30'b0, r_k};
        if (w_store) begin
          mem_wr   = 1'b1;
          mem_dout = r_sdata[{r_k, 3'b000} +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ls_ctrl.sv
// Scoreboard bench for ls_ctrl: directed scenarios plus randomized loads/stores against a
// byte-array reference memory.
module tb_ls_ctrl;
  import ls_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rdy = 1'b1;
  logic       rs_busy = 1'b0;
  sinst_t     rs_op = LB;
  word_t      rs_offset = '0, rs_datax = '0, rs_datay = '0;
  regtag_t    rs_tagx = UNLOCKED, rs_tagy = UNLOCKED, rs_tagw = UNLOCKED;
  logic       busy_ls, en_ls;
  word_t      ls_data;
  regtag_t    ls_tag;
  logic       if_req = 1'b0;
  word_t      if_addr = '0;
  logic       if_gnt;
  word_t      mem_a;
  logic [7:0] mem_dout;
  logic [7:0] mem_din = '0;
  logic       mem_wr;
`ifdef LS_MISALIGN_CHECK_EN
  logic       misalign;
`endif

  ls_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rs_busy(rs_busy), .rs_op(rs_op),
    .rs_offset(rs_offset), .rs_datax(rs_datax), .rs_datay(rs_datay),
    .rs_tagx(rs_tagx), .rs_tagy(rs_tagy), .rs_tagw(rs_tagw),
    .busy_ls(busy_ls), .en_ls(en_ls), .ls_data(ls_data), .ls_tag(ls_tag),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din), .mem_wr(mem_wr)
`ifdef LS_MISALIGN_CHECK_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { regtag_t tag; word_t data; logic mis; } exp_t;
  typedef struct { word_t a; logic [7:0] d; } wr_t;

  exp_t       exp_q[$];
  wr_t        wlog[$];
  logic [7:0] dmem    [0:4095];
  logic [7:0] ref_mem [0:4095];
  int         total = 0;
  int         bad = 0;
  logic       rnd_en = 1'b0;
  logic       dir_req = 1'b0;
  word_t      dir_addr = '0;
  sinst_t     ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", nm, act, req);
    end
  endtask

  // Byte-wide memory: registered read, so data follows the address by one cycle.
  always @(posedge clk) begin
    if (mem_wr) dmem[mem_a[11:0]] <= mem_dout;
    mem_din <= dmem[mem_a[11:0]];
  end

  // Sole driver of rdy / fetch request, changed mid-cycle away from both edges.
  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_en) begin
      rdy     = ($urandom_range(0, 7) != 0);
      if_req  = $urandom_range(0, 1) == 1;
      if_addr = $urandom;
    end else begin
      rdy     = 1'b1;
      if_req  = dir_req;
      if_addr = dir_addr;
    end
  end

  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (mem_wr) wlog.push_back('{mem_a, mem_dout});
      if (if_gnt) begin
        chk("gnt_addr", mem_a, if_addr);
        chk1("gnt_wr", mem_wr, 1'b0);
      end
      if (!rdy) begin
        chk1("frozen_wr", mem_wr, 1'b0);
        chk1("frozen_gnt", if_gnt, 1'b0);
      end
      if (en_ls) begin
        if (exp_q.size() == 0) chk("pending_exp", 32'(exp_q.size()), 32'd1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ls_data", ls_data, e.data);
          chk("ls_tag", 32'(ls_tag), 32'(e.tag));
`ifdef LS_MISALIGN_CHECK_EN
          chk1("misalign", misalign, e.mis);
`endif
        end
      end
    end
  end

  // Reference: apply the architectural effect of one load/store to the byte array.
  task automatic push_exp(input sinst_t op, input word_t base, input word_t off,
                          input word_t sd, input regtag_t tw);
    word_t  a;
    word_t  ak;
    int     n;
    logic   st, sgn;
    longint v;
    exp_t   e;
    a = base + off;
    case (op)
      LB, LBU, SB: n = 1;
      LH, LHU, SH: n = 2;
      default:     n = 4;
    endcase
    st  = (op == SB) || (op == SH) || (op == SW);
    sgn = (op == LB) || (op == LH);
    e.tag = tw; e.data = '0; e.mis = 1'b0;
`ifdef LS_MISALIGN_CHECK_EN
    if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) begin
      e.mis = 1'b1;
      exp_q.push_back(e);
      return;
    end
`endif
    v = 0;
    for (int k = 0; k < n; k++) begin
      ak = a + word_t'(k);
      if (st) ref_mem[ak[11:0]] = sd[8*k +: 8];
      else v += longint'(ref_mem[ak[11:0]]) << (8 * k);
    end
    if (!st) begin
      if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      e.data = v[31:0];
    end
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy_ls; i++) @(negedge clk);
    chk1("idle_timeout", busy_ls, 1'b0);
  endtask

  task automatic wait_done(inout int cnt);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); cnt++;
      @(negedge clk);
      if (en_ls) begin ok = 1'b1; break; end
    end
    chk1("done_timeout", ok, 1'b1);
  endtask

  task automatic do_op(input sinst_t op, input word_t base, input word_t off,
                       input word_t sd, input regtag_t tw, output int lat);
    int   cnt;
    logic ok;
    wait_idle();
    push_exp(op, base, off, sd, tw);
    rs_op = op; rs_datax = base; rs_offset = off; rs_datay = sd; rs_tagw = tw;
    rs_tagx = UNLOCKED; rs_tagy = UNLOCKED; rs_busy = 1'b1;
    cnt = 0; ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); cnt++;
      @(negedge clk);
      if (busy_ls) begin ok = 1'b1; break; end
    end
    chk1("accept", ok, 1'b1);
    // The station may move on immediately; the unit must use its latched copy.
    rs_busy = 1'b0; rs_datax = $urandom; rs_offset = $urandom; rs_datay = $urandom;
    rs_tagw = regtag_t'($urandom);
    wait_done(cnt);
    lat = cnt;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int nm;
    logic [7:0] b;
    for (int i = 0; i < 4096; i++) begin
      b = 8'($urandom);
      dmem[i] <= b;
      ref_mem[i] = b;
    end
    dir_req = 1'b1; dir_addr = 32'h0000_0ABC;
    rs_op = LW; rs_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk1("rst_busy", busy_ls, 1'b0);
    chk1("rst_en", en_ls, 1'b0);
    chk("rst_data", ls_data, 32'h0);
    chk("rst_tag", 32'(ls_tag), 32'(UNLOCKED));
    chk1("rst_wr", mem_wr, 1'b0);
    chk("rst_a", mem_a, 32'h0);
    chk("rst_dout", 32'(mem_dout), 32'h0);
    chk1("rst_gnt", if_gnt, 1'b0);
    rs_busy = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    dmem[12'h104] <= 8'h11; dmem[12'h105] <= 8'h22; dmem[12'h106] <= 8'h33; dmem[12'h107] <= 8'h44;
    ref_mem[12'h104] = 8'h11; ref_mem[12'h105] = 8'h22; ref_mem[12'h106] = 8'h33; ref_mem[12'h107] = 8'h44;
    do_op(LW, 32'h100, 32'h4, 32'h0, 5'd7, lat);
    chk("lw_latency", lat, 7);
    chk("lw_data", ls_data, 32'h4433_2211);

    dmem[12'h050] <= 8'h80; ref_mem[12'h050] = 8'h80;
    do_op(LB, 32'h40, 32'h10, 32'h0, 5'd3, lat);
    chk("lb_latency", lat, 4);
    chk("lb_data", ls_data, 32'hFFFF_FF80);
    do_op(LBU, 32'h40, 32'h10, 32'h0, 5'd4, lat);
    chk("lbu_data", ls_data, 32'h0000_0080);

    wait_idle();
    wlog.delete();
    do_op(SH, 32'h200, 32'h0, 32'h0000_ABCD, 5'd9, lat);
    chk("sh_latency", lat, 4);
    chk("sh_data", ls_data, 32'h0);
    chk("sh_nwr", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      chk("sh_a0", wlog[0].a, 32'h200); chk("sh_d0", 32'(wlog[0].d), 32'hCD);
      chk("sh_a1", wlog[1].a, 32'h201); chk("sh_d1", 32'(wlog[1].d), 32'hAB);
    end

    wait_idle();
    dir_addr = 32'h555;
    @(negedge clk);
    push_exp(LW, 32'h10, 32'h30, 32'h0, 5'd12);
    rs_op = LW; rs_datax = 32'h10; rs_offset = 32'h30; rs_tagw = 5'd12;
    rs_tagx = 5'd3; rs_busy = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk1("lock_gnt", if_gnt, 1'b1);
      chk1("lock_busy", busy_ls, 1'b0);
      chk("lock_a", mem_a, 32'h555);
    end
    rs_tagx = UNLOCKED;
    @(negedge clk);
    chk1("unlock_busy", busy_ls, 1'b1);
    chk1("addr_gnt", if_gnt, 1'b1);
    rs_busy = 1'b0;
    @(negedge clk);
    chk1("access_gnt", if_gnt, 1'b0);
    chk("access_a", mem_a, 32'h40);
    lat = 0;
    wait_done(lat);

    wait_idle();
    wlog.delete();
    rs_op = SW; rs_datax = 32'h300; rs_offset = 32'h0; rs_datay = 32'hDEAD_BEEF;
    rs_tagw = 5'd20; rs_tagx = UNLOCKED; rs_tagy = UNLOCKED; rs_busy = 1'b1;
    @(negedge clk);
    chk1("sw_busy", busy_ls, 1'b1);
    rs_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("sw_b2_a", mem_a, 32'h302);
    rst = 1'b0;
    #1;
    chk1("mid_rst_wr", mem_wr, 1'b0);
    chk("mid_rst_a", mem_a, 32'h0);
    chk1("mid_rst_busy", busy_ls, 1'b0);
    chk1("mid_rst_gnt", if_gnt, 1'b0);
    chk("mid_rst_tag", 32'(ls_tag), 32'(UNLOCKED));
    ref_mem[12'h300] = 8'hEF; ref_mem[12'h301] = 8'hBE;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("sw_rst_nwr", 32'(wlog.size()), 32'd2);

    rnd_en = 1'b1;
    repeat (80) begin
      do_op(ops[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
            regtag_t'($urandom_range(1, 31)), lat);
    end
    rnd_en = 1'b0;
    repeat (3) @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    nm = 0;
    for (int i = 0; i < 4096; i++) if (dmem[i] !== ref_mem[i]) nm++;
    chk("mem_image", nm, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
